// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Bundles the core-side request/response handshake and the data_memory port
// of the load/store unit.
//   slave  : the load/store unit itself
//   master : the core plus data_memory (the environment around the unit)
// Core side   : req_i, we_i, size_i, unsigned_i, addr_i, wd_i  -> unit
//               rdata_o, ready_o, fault_o, busy_o               <- unit
// Memory side : mem_addr_o, mem_wd_o, mem_we_o                  <- unit
//               mem_rd_i (combinational from mem_addr_o)        -> unit
// ---------------------------------------------------------------------------
interface load_store_unit_if;
   logic        req_i;
   logic        we_i;
   logic [1:0]  size_i;
   logic        unsigned_i;
   logic [31:0] addr_i;
   logic [31:0] wd_i;
   logic [31:0] rdata_o;
   logic        ready_o;
   logic        fault_o;
   logic        busy_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wd_o;
   logic        mem_we_o;
   logic [31:0] mem_rd_i;

   modport slave (
      input  req_i, we_i, size_i, unsigned_i, addr_i, wd_i, mem_rd_i,
      output rdata_o, ready_o, fault_o, busy_o, mem_addr_o, mem_wd_o, mem_we_o
   );

   modport master (
      output req_i, we_i, size_i, unsigned_i, addr_i, wd_i, mem_rd_i,
      input  rdata_o, ready_o, fault_o, busy_o, mem_addr_o, mem_wd_o, mem_we_o
   );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Sequential front end between the execute stage and data_memory. Turns
// byte/half/word loads and stores into word-aligned memory accesses:
// sub-word stores are read-modify-write, loads are lane-extracted and
// sign/zero-extended, size/alignment violations are reported as faults.
//
// Parameters : BASE_ADDR - first byte address of data memory
//              MEM_BYTES - data memory size in bytes (multiple of 4)
// Ports      : clk_i  - clock, rising edge
//              rst_i  - asynchronous active-high reset
//              bus    - load_store_unit_if.slave (request, response and
//                       data_memory signals)
// Build option: define LSU_RANGE_CHECK_EN to additionally fault requests
//              whose address lies outside [BASE_ADDR, BASE_ADDR+MEM_BYTES).
// ---------------------------------------------------------------------------
module load_store_unit #(
   parameter logic [31:0] BASE_ADDR = 32'h66000000,
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic             clk_i,
   input  logic             rst_i,
   load_store_unit_if.slave bus
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   // Memory must be whole, word-aligned words.
   if ((MEM_BYTES % 4) != 0 || BASE_ADDR[1:0] != 2'b00) begin : g_bad_cfg
      $error("load_store_unit: BASE_ADDR/MEM_BYTES must be word aligned");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RMW_READ,
      S_WRITE,
      S_RESP
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_addr;
   logic [31:0] r_wd;
   logic [1:0]  r_size;
   logic        r_uns;
   logic        r_fault;
   logic [31:0] r_rdata;
   logic [31:0] r_merge;

   logic        w_acc_fault;
   logic        w_range_fault;
   logic        w_ready;
   logic        w_busy;
   logic        w_we;

   // Extract the addressed lane of a memory word and extend it to 32 bits.
   function automatic logic [31:0] f_load_extend(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        uns);
      logic signed [7:0]  v_b;
      logic signed [15:0] v_h;
      logic [31:0]        v_res;
      v_b = signed'(word[{lane, 3'b000} +: 8]);
      v_h = signed'(word[{lane[1], 4'b0000} +: 16]);
      case (size)
         SZ_BYTE: v_res = uns ? {24'h0, v_b} : 32'(v_b);
         SZ_HALF: v_res = uns ? {16'h0, v_h} : 32'(v_h);
         default: v_res = word;
      endcase
      return v_res;
   endfunction

   // Replace only the addressed byte/half of a memory word with store data.
   function automatic logic [31:0] f_store_merge(input logic [31:0] word,
                                                 input logic [31:0] wd,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane);
      logic [31:0] v_res;
      v_res = word;
      if (size == SZ_BYTE) v_res[{lane, 3'b000} +: 8] = wd[7:0];
      else                 v_res[{lane[1], 4'b0000} +: 16] = wd[15:0];
      return v_res;
   endfunction

`ifdef LSU_RANGE_CHECK_EN
   // 33-bit compare so a memory ending at 2^32 does not wrap.
   localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(MEM_BYTES);
   assign w_range_fault = ({1'b0, bus.addr_i} < {1'b0, BASE_ADDR}) ||
                          ({1'b0, bus.addr_i} >= LIMIT);
`else
   assign w_range_fault = 1'b0;
`endif

   assign w_acc_fault = (bus.size_i == SZ_ILL) ||
                        (bus.size_i == SZ_HALF && bus.addr_i[0]) ||
                        (bus.size_i == SZ_WORD && bus.addr_i[1:0] != 2'b00) ||
                        w_range_fault;

   // ---- state register ----
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // ---- next state and state-decoded outputs ----
   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_busy  = 1'b1;
      w_we    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (bus.req_i) begin
               if (w_acc_fault)              w_next = S_RESP;
               else if (!bus.we_i)           w_next = S_LOAD;
               else if (bus.size_i == SZ_WORD) w_next = S_WRITE;
               else                          w_next = S_RMW_READ;
            end
         end
         S_LOAD:     w_next = S_RESP;
         S_RMW_READ: w_next = S_WRITE;
         S_WRITE: begin
            w_we   = 1'b1;
            w_next = S_RESP;
         end
         S_RESP: begin
            w_ready = 1'b1;
            w_next  = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // ---- request latch, load result and merge register ----
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_addr  <= '0;
         r_wd    <= '0;
         r_size  <= '0;
         r_uns   <= 1'b0;
         r_fault <= 1'b0;
         r_rdata <= '0;
         r_merge <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (bus.req_i) begin
               r_addr  <= bus.addr_i;
               r_wd    <= bus.wd_i;
               r_size  <= bus.size_i;
               r_uns   <= bus.unsigned_i;
               r_fault <= w_acc_fault;
            end
            S_LOAD:     r_rdata <= f_load_extend(bus.mem_rd_i, r_size, r_addr[1:0], r_uns);
            S_RMW_READ: r_merge <= f_store_merge(bus.mem_rd_i, r_wd, r_size, r_addr[1:0]);
            default: ;
         endcase
      end
   end

   assign bus.rdata_o    = r_rdata;
   assign bus.ready_o    = w_ready;
   assign bus.fault_o    = w_ready & r_fault;
   assign bus.busy_o     = w_busy;
   assign bus.mem_we_o   = w_we;
   assign bus.mem_addr_o = {r_addr[31:2], 2'b00};
   assign bus.mem_wd_o   = (r_size == SZ_WORD) ? r_wd : r_merge;

endmodule
